// File: rtl/axis_pkt_sched.sv
// Round-robin packet scheduler: shares one AXI4-Stream master between N_CH
// show-ahead FIFOs, granting only channels that already hold a full packet.
module axis_pkt_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CH_WIDTH   = 2,
  parameter int unsigned LVL_WIDTH  = 10,
  parameter int unsigned PKT_LEN    = 512
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [N_CH*DATA_WIDTH-1:0]    i_fifo_data,
  input  logic [N_CH*LVL_WIDTH-1:0]     i_fifo_level,
  output logic [N_CH-1:0]               o_fifo_rd,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic [CH_WIDTH-1:0]           m_axis_tdest,
  output logic                          o_busy,
  output logic [31:0]                   o_pkt_count
);

  localparam int unsigned CNT_W = $clog2(PKT_LEN);
  localparam int unsigned N_IDX = 1 << CH_WIDTH;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_LAST} state_t;

  state_t                state_q, state_d;
  logic [CH_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [CH_WIDTH-1:0]   tdest_q, tdest_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] ch_data [N_IDX];
  logic [N_CH-1:0]       eligible;
  logic [CH_WIDTH-1:0]   hi_sel, lo_sel, grant_sel;
  logic                  hi_found, lo_found;
  logic                  ld;
  logic                  rd_en;

  // Unpack per-channel head words (padded to a full index range) and eligibility.
  for (genvar c = 0; c < N_IDX; c++) begin : g_ch
    if (c < N_CH) begin : g_used
      assign ch_data[c]  = i_fifo_data[c*DATA_WIDTH +: DATA_WIDTH];
      assign eligible[c] = i_fifo_level[c*LVL_WIDTH +: LVL_WIDTH] >= LVL_WIDTH'(PKT_LEN);
    end else begin : g_pad
      assign ch_data[c] = '0;
    end
  end

  // Rotating priority: lowest eligible above last_grant, else lowest eligible overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int c = int'(N_CH) - 1; c >= 0; c--) begin
      if (eligible[c]) begin
        lo_found = 1'b1;
        lo_sel   = CH_WIDTH'(c);
        if (CH_WIDTH'(c) > last_grant_q) begin
          hi_found = 1'b1;
          hi_sel   = CH_WIDTH'(c);
        end
      end
    end
    grant_sel = hi_found ? hi_sel : lo_sel;
  end

  assign ld = !tvalid_q || m_axis_tready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdest_d      = tdest_q;
    pkt_cnt_d    = pkt_cnt_q;
    rd_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && lo_found) begin
          last_grant_d = grant_sel;
          tdest_d      = grant_sel;
          word_cnt_d   = '0;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (ld) begin
          tdata_d    = ch_data[last_grant_q];
          tvalid_d   = 1'b1;
          rd_en      = 1'b1;
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (word_cnt_q == CNT_W'(PKT_LEN - 1)) begin
            tlast_d = 1'b1;
            state_d = WAIT_LAST;
          end
        end
      end
      WAIT_LAST: begin
        if (m_axis_tready) begin
          tvalid_d  = 1'b0;
          tlast_d   = 1'b0;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= CH_WIDTH'(N_CH - 1);
      word_cnt_q   <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdest_q      <= '0;
      pkt_cnt_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdest_q      <= tdest_d;
      pkt_cnt_q    <= pkt_cnt_d;
      busy_q       <= busy_d;
    end
  end

  // FIFO advance must coincide with the output-register load, so it is combinational.
  always_comb begin
    o_fifo_rd = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      o_fifo_rd[c] = rd_en && !rst && (last_grant_q == CH_WIDTH'(c));
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdest  = tdest_q;
  assign m_axis_tkeep  = '1;
  assign o_busy        = busy_q;
  assign o_pkt_count   = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_sched.sv
// Scoreboard bench for axis_pkt_sched: FIFO models feed the DUT, a packet-level
// round-robin model predicts the beat stream, a negedge monitor checks it.
module tb_axis_pkt_sched;

  localparam int DW    = 32;
  localparam int NC    = 4;
  localparam int CW    = 2;
  localparam int LW    = 10;
  localparam int PL    = 512;
  localparam int DEPTH = 8192;

  typedef struct packed {
    logic [CW-1:0] dest;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [NC*DW-1:0]  i_fifo_data;
  logic [NC*LW-1:0]  i_fifo_level;
  logic [NC-1:0]     o_fifo_rd;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [DW/8-1:0]   m_axis_tkeep;
  logic [CW-1:0]     m_axis_tdest;
  logic              o_busy;
  logic [31:0]       o_pkt_count;

  axis_pkt_sched #(
    .DATA_WIDTH(DW), .N_CH(NC), .CH_WIDTH(CW), .LVL_WIDTH(LW), .PKT_LEN(PL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .i_fifo_data(i_fifo_data), .i_fifo_level(i_fifo_level), .o_fifo_rd(o_fifo_rd),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tdest(m_axis_tdest),
    .o_busy(o_busy), .o_pkt_count(o_pkt_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Show-ahead FIFO models: fixed random contents, bench advances wr_ptr, DUT advances rd_ptr.
  logic [DW-1:0] mem [NC][DEPTH];
  int wr_ptr [NC];
  int rd_ptr [NC];
  logic flush;

  // Reference model state.
  beat_t exp_q [$];
  int m_rd [NC];
  int m_last;
  int m_pkts;

  logic rand_rdy;
  int   pkt_beat;
  int   gap;
  bit   gap_armed;
  bit   pc_chk;
  bit   prev_stall;
  logic [DW+CW+1:0] prev_bus;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar c = 0; c < NC; c++) begin : g_fifo
    assign i_fifo_data[c*DW +: DW] = mem[c][rd_ptr[c][12:0]];
    assign i_fifo_level[c*LW +: LW] = ((wr_ptr[c] - rd_ptr[c]) > 1023) ? LW'(1023)
                                                                       : LW'(wr_ptr[c] - rd_ptr[c]);
  end

  always @(posedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (flush) rd_ptr[c] <= wr_ptr[c];
      else if (o_fifo_rd[c]) rd_ptr[c] <= rd_ptr[c] + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level round robin over the model's own fill counts.
  task automatic predict(input int max_pkts);
    int n;
    int c;
    bit found;
    beat_t b;
    n = 0;
    found = 1'b1;
    while (found && n < max_pkts) begin
      found = 1'b0;
      for (int i = 1; i <= NC; i++) begin
        c = (m_last + i) % NC;
        if (!found && (wr_ptr[c] - m_rd[c]) >= PL) begin
          found = 1'b1;
          for (int k = 0; k < PL; k++) begin
            b.dest = CW'(c);
            b.last = (k == PL - 1);
            b.data = mem[c][(m_rd[c] + k) % DEPTH];
            exp_q.push_back(b);
          end
          m_rd[c] += PL;
          m_last = c;
          n++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && !o_busy) && i < 6000) begin
      @(negedge clk);
      i++;
    end
    check("phase_done", (exp_q.size() == 0 && !o_busy), 1);
    repeat (4) @(negedge clk);
    check("pkt_count_end", o_pkt_count, m_pkts);
    for (int c = 0; c < NC; c++) check($sformatf("rd_words_ch%0d", c), rd_ptr[c], m_rd[c]);
  endtask

  task automatic wait_beat(input int n);
    int i;
    i = 0;
    while (pkt_beat < n && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check("reach_beat", pkt_beat >= n, 1);
  endtask

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks protocol rules.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      pkt_beat   = 0;
      gap_armed  = 1'b0;
      pc_chk     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (pc_chk) begin
        check("pkt_count_after_last", o_pkt_count, m_pkts);
        pc_chk = 1'b0;
      end
      if (prev_stall)
        check("hold_while_stalled", {m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tdata}, prev_bus);
      if (o_fifo_rd != '0) begin
        check("rd_onehot", $countones(o_fifo_rd), 1);
        check("rd_on_load", (!m_axis_tvalid || m_axis_tready), 1);
        for (int c = 0; c < NC; c++)
          if (o_fifo_rd[c]) check("rd_nonempty", (wr_ptr[c] > rd_ptr[c]), 1);
      end
      if (gap_armed) begin
        if (m_axis_tvalid) begin
          check("interpacket_gap", gap, 2);
          gap_armed = 1'b0;
        end else begin
          gap++;
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", {m_axis_tdest, m_axis_tlast, m_axis_tdata}, e);
        end
        pkt_beat++;
        if (m_axis_tlast) begin
          pkt_beat  = 0;
          m_pkts++;
          pc_chk    = 1'b1;
          gap       = 0;
          gap_armed = (exp_q.size() != 0) && enable;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_bus   = {m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tdata};
    end
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    flush    = 1'b0;
    rand_rdy = 1'b0;
    m_last   = NC - 1;
    m_pkts   = 0;
    for (int c = 0; c < NC; c++) begin
      wr_ptr[c] = 0;
      m_rd[c]   = 0;
      for (int i = 0; i < DEPTH; i++) mem[c][i] = $urandom;
    end

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tdest", m_axis_tdest, 0);
    check("rst_fifo_rd", o_fifo_rd, 0);
    check("rst_busy", o_busy, 0);
    check("rst_pkt_count", o_pkt_count, 0);
    check("tkeep", m_axis_tkeep, 4'hF);
    step();
    rst = 1'b0;

    // Single packet from channel 0
    wr_ptr[0] += PL;
    predict(100);
    enable = 1'b1;
    wait_done();
    step();
    enable = 1'b0;

    // All channels loaded with two packets each
    for (int c = 0; c < NC; c++) wr_ptr[c] += 1024;
    predict(100);
    enable = 1'b1;
    wait_done();
    step();
    enable = 1'b0;

    // Random backpressure
    rand_rdy = 1'b1;
    wr_ptr[1] += PL;
    wr_ptr[2] += PL;
    predict(100);
    enable = 1'b1;
    wait_done();
    step();
    enable = 1'b0;

    // One word short of a packet is never eligible
    wr_ptr[2] += PL - 1;
    wr_ptr[3] += PL;
    predict(100);
    enable = 1'b1;
    wait_done();
    step();
    enable = 1'b0;
    wr_ptr[2] += 1;
    predict(100);
    enable = 1'b1;
    wait_done();
    step();
    enable = 1'b0;

    // Enable dropped mid-packet
    wr_ptr[0] += PL;
    wr_ptr[1] += PL;
    predict(1);
    enable = 1'b1;
    wait_beat(100);
    step();
    enable = 1'b0;
    wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", o_busy, 0);
      check("idle_tvalid", m_axis_tvalid, 0);
    end
    step();
    predict(100);
    enable = 1'b1;
    wait_done();
    step();

    // Reset mid-packet
    wr_ptr[3] += PL;
    predict(1);
    wait_beat(300);
    step();
    rst    = 1'b1;
    flush  = 1'b1;
    enable = 1'b0;
    exp_q.delete();
    m_last = NC - 1;
    m_pkts = 0;
    for (int c = 0; c < NC; c++) m_rd[c] = wr_ptr[c];
    step();
    rst   = 1'b0;
    flush = 1'b0;
    check("post_rst_tvalid", m_axis_tvalid, 0);
    check("post_rst_tlast", m_axis_tlast, 0);
    check("post_rst_busy", o_busy, 0);
    check("post_rst_pkt_count", o_pkt_count, 0);
    check("post_rst_tdest", m_axis_tdest, 0);
    wr_ptr[1] += PL;
    wr_ptr[0] += PL;
    predict(100);
    enable = 1'b1;
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
